// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter family: direction encoding and end-of-range mode.
// Pure declarations, no logic; no latency or flow control.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } mode_e;

endpackage

// File: rtl/counter_next_val.sv
// Next modulo value and at-terminal flag for one step in the requested direction.
// Combinational (0 cycles); no flow control.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_val,
    output logic             at_terminal
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Wrap target is explicit, so a full-range modulus gives the same result as natural overflow.
    always_comb begin
        next_val    = count;
        at_terminal = 1'b0;
        if (up_dn == DIR_UP) begin
            at_terminal = (count == MAX_VAL);
            next_val    = at_terminal ? '0 : count + ONE;
        end else begin
            at_terminal = (count == '0);
            next_val    = at_terminal ? MAX_VAL : count - ONE;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with load, clear, wrap/saturate mode, terminal count and divided toggle.
// count/wrap/div_out update on the sampling edge, tc is combinational; no backpressure, cascade via tc->en.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             div_out
);

    localparam mode_e            MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] load_clamped;
    logic             at_terminal;
    logic             wrap_evt;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count       (count),
        .up_dn       (up_dn),
        .next_val    (next_val),
        .at_terminal (at_terminal)
    );

    // Out-of-range loads pin to the top of the range instead of entering unreachable states.
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign tc           = en & ~clear & ~load & at_terminal;
    assign wrap_evt     = tc & (MODE == MODE_WRAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            wrap    <= 1'b0;
            div_out <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
            if (!(at_terminal && (MODE == MODE_SAT))) begin
                count <= next_val;
            end
            wrap <= wrap_evt;
            if (wrap_evt) begin
                div_out <= ~div_out;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: wrap and saturate instances share stimulus, plus a 4+4 bit cascade.
// Reference model tracks each instance's counter as a plain integer in 0..MODULUS-1.
module tb_mod_updown_counter;

    localparam int MODV = 10;

    logic       clk = 1'b0;
    logic       rst_n, en, up_dn, load, clear;
    logic [3:0] load_val;
    logic [3:0] count_w, count_s;
    logic       tc_w, tc_s, wrap_w, wrap_s, div_w, div_s;

    logic       c_rst_n, c_en;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_div, hi_div;

    int vectors    = 0;
    int miscompares = 0;

    int m_cnt  [2];
    bit m_wrap [2];
    bit m_div  [2];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .clear(clear), .count(count_w), .tc(tc_w), .wrap(wrap_w), .div_out(div_w));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .clear(clear), .count(count_s), .tc(tc_s), .wrap(wrap_s), .div_out(div_s));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_lo (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'h0),
        .clear(1'b0), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .div_out(lo_div));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_hi (
        .clk(clk), .rst_n(c_rst_n), .en(lo_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'h0),
        .clear(1'b0), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .div_out(hi_div));

    // ---------------- reference model ----------------
    function automatic bit model_tc(int i);
        int term = up_dn ? MODV - 1 : 0;
        return en && !clear && !load && (m_cnt[i] == term);
    endfunction

    function automatic void model_update(int i);
        bit sat = (i == 1);
        if (!rst_n) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_div[i] = 0;
        end else if (clear) begin
            m_cnt[i] = 0; m_wrap[i] = 0;
        end else if (load) begin
            m_cnt[i] = (int'(load_val) >= MODV) ? MODV - 1 : int'(load_val);
            m_wrap[i] = 0;
        end else if (en) begin
            int raw = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
            bool_wrap: begin
                bit crossed = (raw < 0) || (raw >= MODV);
                m_wrap[i] = crossed && !sat;
                if (!crossed) m_cnt[i] = raw;
                else if (!sat) begin
                    m_cnt[i] = (raw + MODV) % MODV;
                    m_div[i] = !m_div[i];
                end
            end
        end else begin
            m_wrap[i] = 0;
        end
    endfunction

    function automatic logic [11:0] obs_state();
        return {count_w, wrap_w, div_w, count_s, wrap_s, div_s};
    endfunction

    function automatic logic [11:0] exp_state();
        return {4'(m_cnt[0]), m_wrap[0], m_div[0], 4'(m_cnt[1]), m_wrap[1], m_div[1]};
    endfunction

    // One clock edge with the current inputs; the model consumes the same sampled inputs.
    task automatic edge_step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_update(i);
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic u, input logic l,
                          input logic [3:0] lv, input logic c);
        rst_n = r; en = e; up_dn = u; load = l; load_val = lv; clear = c;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_in(0, 1, 1, 1, 4'd5, 0);
        edge_step();
        edge_step();
        vectors++;
        if (obs_state() !== 12'h000 || obs_state() !== exp_state()) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", obs_state(), exp_state());
        end
    endtask

    task automatic test_count_up();
        set_in(1, 1, 1, 0, 4'd0, 0);
        for (int k = 1; k <= 25; k++) begin
            #1;
            vectors++;
            if ({tc_w, tc_s} !== {model_tc(0), model_tc(1)}) begin
                miscompares++;
                $display("FAIL up_tc cyc=%0d got=%b exp=%b", k, {tc_w, tc_s}, {model_tc(0), model_tc(1)});
            end
            edge_step();
            vectors++;
            if (obs_state() !== exp_state()) begin
                miscompares++;
                $display("FAIL up_state cyc=%0d got=%h exp=%h", k, obs_state(), exp_state());
            end
            vectors++;
            if (count_w !== 4'(k % 10) || wrap_w !== (k % 10 == 0)) begin
                miscompares++;
                $display("FAIL up_seq cyc=%0d got=%0d/%b exp=%0d/%b", k, count_w, wrap_w, k % 10, (k % 10 == 0));
            end
        end
        vectors++;
        if (div_w !== 1'b0) begin
            miscompares++;
            $display("FAIL up_div_final got=%b exp=0", div_w);
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_seq [2];
        exp_seq[0] = 4'd9;
        exp_seq[1] = 4'd8;
        set_in(1, 0, 0, 0, 4'd0, 1);
        edge_step();
        set_in(1, 1, 0, 0, 4'd0, 0);
        #1;
        vectors++;
        if (tc_w !== 1'b1) begin
            miscompares++;
            $display("FAIL down_tc got=%b exp=1", tc_w);
        end
        for (int k = 0; k < 2; k++) begin
            edge_step();
            vectors++;
            if (count_w !== exp_seq[k] || wrap_w !== (k == 0) || obs_state() !== exp_state()) begin
                miscompares++;
                $display("FAIL down_seq step=%0d got=%0d wrap=%b exp=%0d wrap=%b", k, count_w, wrap_w, exp_seq[k], (k == 0));
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
        set_in(1, 0, 1, 1, 4'd7, 0);
        edge_step();
        set_in(1, 1, 1, 0, 4'd0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (tc_s !== (k >= 2)) begin
                miscompares++;
                $display("FAIL sat_tc step=%0d got=%b exp=%b", k, tc_s, (k >= 2));
            end
            edge_step();
            vectors++;
            if (count_s !== exp_seq[k] || wrap_s !== 1'b0 || div_s !== 1'b0) begin
                miscompares++;
                $display("FAIL sat_seq step=%0d got=%0d/%b/%b exp=%0d/0/0", k, count_s, wrap_s, div_s, exp_seq[k]);
            end
        end
    endtask

    task automatic test_load_clear();
        set_in(1, 1, 1, 1, 4'd12, 0);
        edge_step();
        vectors++;
        if (count_w !== 4'd9 || count_s !== 4'd9) begin
            miscompares++;
            $display("FAIL load_clamp got=%0d/%0d exp=9/9", count_w, count_s);
        end
        set_in(1, 1, 1, 1, 4'd4, 1);
        edge_step();
        vectors++;
        if (count_w !== 4'd0 || obs_state() !== exp_state()) begin
            miscompares++;
            $display("FAIL clear_over_load got=%0d exp=0", count_w);
        end
        set_in(1, 0, 1, 1, 4'd9, 0);
        edge_step();
        set_in(1, 1, 1, 1, 4'd3, 0);
        #1;
        vectors++;
        if (tc_w !== 1'b0) begin
            miscompares++;
            $display("FAIL load_masks_tc got=%b exp=0", tc_w);
        end
        edge_step();
        vectors++;
        if (count_w !== 4'd3 || wrap_w !== 1'b0 || obs_state() !== exp_state()) begin
            miscompares++;
            $display("FAIL load_over_en got=%0d wrap=%b exp=3 wrap=0", count_w, wrap_w);
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 1, 1, 4'd5, 0);
        edge_step();
        set_in(1, 1, 1, 0, 4'd0, 0);
        edge_step();
        vectors++;
        if (count_w !== 4'd6) begin
            miscompares++;
            $display("FAIL mid_setup got=%0d exp=6", count_w);
        end
        set_in(0, 1, 1, 0, 4'd0, 0);
        edge_step();
        vectors++;
        if (count_w !== 4'd0 || wrap_w !== 1'b0 || div_w !== 1'b0 || obs_state() !== exp_state()) begin
            miscompares++;
            $display("FAIL mid_reset got=%h exp=%h", obs_state(), exp_state());
        end
        set_in(1, 1, 1, 0, 4'd0, 0);
        for (int k = 1; k <= 3; k++) begin
            edge_step();
            vectors++;
            if (count_w !== 4'(k)) begin
                miscompares++;
                $display("FAIL mid_resume step=%0d got=%0d exp=%0d", k, count_w, k);
            end
        end
    endtask

    task automatic test_dir_flip();
        set_in(1, 0, 1, 1, 4'd9, 0);
        edge_step();
        set_in(1, 1, 0, 0, 4'd0, 0);
        #1;
        vectors++;
        if (tc_w !== 1'b0 || tc_s !== 1'b0) begin
            miscompares++;
            $display("FAIL flip_tc got=%b/%b exp=0/0", tc_w, tc_s);
        end
        edge_step();
        vectors++;
        if (count_w !== 4'd8 || wrap_w !== 1'b0 || count_s !== 4'd8) begin
            miscompares++;
            $display("FAIL flip_step got=%0d/%b/%0d exp=8/0/8", count_w, wrap_w, count_s);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                   ($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
            #1;
            vectors++;
            if ({tc_w, tc_s} !== {model_tc(0), model_tc(1)}) begin
                miscompares++;
                $display("FAIL rand_tc cyc=%0d got=%b exp=%b", k, {tc_w, tc_s}, {model_tc(0), model_tc(1)});
            end
            edge_step();
            vectors++;
            if (obs_state() !== exp_state()) begin
                miscompares++;
                $display("FAIL rand_state cyc=%0d got=%h exp=%h", k, obs_state(), exp_state());
            end
        end
    endtask

    task automatic test_cascade();
        c_rst_n = 1'b0;
        c_en    = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({hi_count, lo_count} !== 8'h00) begin
            miscompares++;
            $display("FAIL casc_reset got=%h exp=00", {hi_count, lo_count});
        end
        c_rst_n = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({hi_count, lo_count} !== 8'(k % 256)) begin
                miscompares++;
                $display("FAIL casc_count cyc=%0d got=%h exp=%h", k, {hi_count, lo_count}, 8'(k % 256));
            end
        end
        vectors++;
        if ({hi_count, lo_count} !== 8'h2C) begin
            miscompares++;
            $display("FAIL casc_final got=%h exp=2c", {hi_count, lo_count});
        end
    endtask

    initial begin
        c_rst_n = 1'b0;
        c_en    = 1'b0;
        set_in(0, 0, 1, 0, 4'd0, 0);
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_div[i] = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_clear();
        test_reset_mid();
        test_dir_flip();
        test_random();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down modulo counter.
- Next generation of the 4-bit ripple divider counter: one clock domain, no derived clocks.
- Adds programmable modulus, direction control, parallel load, synchronous clear and wrap/saturate mode.
- Provides terminal-count and divided-enable outputs so cascades are built by chaining enables, not clocks.

Parameters:
WIDTH, 8, counter register width in bits
MODULUS, 256, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends of the range

Ports:
clk  input  1  single clock, rising-edge active
rst_n  input  1  synchronous active-low reset
en  input  1  count enable; counts one step per clk while high
up_dn  input  1  1 = count up, 0 = count down; sampled when a step occurs
load  input  1  synchronous parallel load
load_val  input  WIDTH  value written on load
clear  input  1  synchronous clear to 0
count  output  WIDTH  registered counter value
tc  output  1  combinational terminal-count flag
wrap  output  1  registered one-cycle pulse after a wrap event
div_out  output  1  registered toggle on every wrap event; frequency = clk / (2*MODULUS)

Behaviour:
- Reset: rst_n=0 at a clk edge gives count=0, wrap=0, div_out=0.
  - Reset has priority over all other inputs.
  - Reset asserted mid-count takes effect at the next edge with no residual pulses.
- Priority of actions at each edge: rst_n > clear > load > en. Exactly one action occurs per edge.
- clear: count <= 0; wrap <= 0; div_out unchanged.
- load: count <= load_val, clamped to MODULUS-1 if load_val >= MODULUS; wrap <= 0; div_out unchanged.
- en=1, up_dn=1:
  - count < MODULUS-1: count <= count+1.
  - count = MODULUS-1, SATURATE=0: count <= 0 (wrap event).
  - count = MODULUS-1, SATURATE=1: count holds.
- en=1, up_dn=0:
  - count > 0: count <= count-1.
  - count = 0, SATURATE=0: count <= MODULUS-1 (wrap event).
  - count = 0, SATURATE=1: count holds.
- en=0 with no clear/load: count holds; wrap <= 0.
- tc = en & ~clear & ~load & (terminal value for the current direction).
  - Terminal value is MODULUS-1 when up_dn=1, 0 when up_dn=0.
  - tc is asserted in both modes; in SATURATE=1 it indicates the counter is pinned at the end of its range.
- Wrap event (SATURATE=0 only): wrap <= 1 for exactly one cycle and div_out <= ~div_out on the same edge.
  - wrap is the registered form of tc, masked by SATURATE.
  - With SATURATE=1, wrap and div_out stay 0 after reset.
- Latency: count, wrap and div_out update on the edge that samples the inputs. tc is valid in the same cycle as its inputs.
- Cascading: the higher stage's en is driven from the lower stage's tc. The next-state logic is pure next-value arithmetic, with no carry into bits >= WIDTH.
- Direction change at a terminal value (for example up_dn flips while count=MODULUS-1): tc follows the new direction combinationally; no wrap occurs unless a step is taken at the terminal value of the current direction.
- MODULUS = 2**WIDTH: wrap comes from natural overflow/underflow with identical results, and the load clamp is inactive.
- Illegal MODULUS (outside 2..2**WIDTH) is rejected at elaboration.

Decomposition:
- Shared package counter_pkg: direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0, and a mode enum {MODE_WRAP, MODE_SAT}.
- One sub-module, counter_next_val (combinational).
  - Inputs: count, up_dn; parameters WIDTH and MODULUS.
  - Outputs: next value and at_terminal flag.
- The top module holds the registers, priority logic, tc, wrap and div_out.

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0; reset, then en=1, up_dn=1 for 25 cycles -> count sequence 0..9,0..9,0..4.
  - tc high while count=9 (cycles 10 and 20).
  - wrap pulses for one cycle after each 9->0 step.
  - div_out toggles 0->1->0.
- Same configuration, up_dn=0 from count=0 -> count goes 0->9->8; tc high while count=0; wrap pulses after the 0->9 step.
- SATURATE=1, MODULUS=10, up from 7 for 5 cycles -> count 8,9,9,9,9; tc stays high from count=9; wrap and div_out remain 0.
- load with load_val=12 (>MODULUS-1) while en=1 -> count=9, no increment that cycle.
  - clear and load together -> count=0.
  - load and en both high at count=9 -> count=load_val and no wrap.
- Mid-count (count=6) with rst_n=0 for one edge while en=1 -> count=0, wrap=0, div_out=0 on the next cycle; counting resumes 1,2,... once rst_n=1.
- WIDTH=4, MODULUS=16: two instances cascaded (upper en = lower tc), 300 cycles from reset -> upper:lower reads 0x12C mod 256 = 0x2C.
